// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line widths plus the L2 arbiter state and source enums.
package lc3b_types;

   localparam int WORD_W    = 16;
   localparam int LINE_BITS = 128;

   typedef logic [WORD_W-1:0]    lc3b_word;
   typedef logic [LINE_BITS-1:0] lc3b_datbus;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      TURN    = 2'd3
   } arb_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } arb_src_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner pick for the L2 port.
// Build option ARB_ROUND_ROBIN_EN: alternate between I and D when both are
// pending; otherwise D has fixed priority unless I has hit its starvation limit.
module arb_grant_sel
   import lc3b_types::*;
(
   input  logic     ic_req,
   input  logic     dc_req,
   input  logic     starve_hit,
   input  arb_src_t rr_last,
   output logic     grant_valid,
   output arb_src_t grant_src
);

`ifdef ARB_ROUND_ROBIN_EN
   logic w_unused_starve;
   assign w_unused_starve = starve_hit;
`else
   logic w_unused_rr;
   assign w_unused_rr = rr_last;
`endif

   // Pick a winner among the pending requesters; a lone requester always wins.
   always_comb begin
      grant_valid = ic_req | dc_req;
      grant_src   = SRC_I;
`ifdef ARB_ROUND_ROBIN_EN
      if (ic_req && dc_req)
         grant_src = (rr_last == SRC_I) ? SRC_D : SRC_I;
      else if (dc_req)
         grant_src = SRC_D;
`else
      if (dc_req && !(ic_req && starve_hit))
         grant_src = SRC_D;
`endif
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache miss paths.
// One line transaction at a time; the winner's request is captured at grant
// and held until L2 responds. Build option ARB_ROUND_ROBIN_EN selects
// round-robin arbitration (see arb_grant_sel).
module l2_port_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W       = $bits(lc3b_word),
   parameter int LINE_W       = $bits(lc3b_datbus),
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_read,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [LINE_W-1:0] ic_rdata,
   output logic              ic_resp,
   input  logic              dc_read,
   input  logic              dc_write,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              dc_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   arb_src_t          r_rr_last;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic              r_write;

   logic              w_grant_valid;
   arb_src_t          w_grant_src;
   logic              w_grant;
   logic              w_starve_hit;

   assign w_starve_hit = (r_starve_cnt == STARVE_MAX);
   assign w_grant      = (r_state == IDLE) && w_grant_valid;

   arb_grant_sel u_grant_sel (
      .ic_req      (ic_read),
      .dc_req      (dc_read | dc_write),
      .starve_hit  (w_starve_hit),
      .rr_last     (r_rr_last),
      .grant_valid (w_grant_valid),
      .grant_src   (w_grant_src)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: grant from IDLE, wait for l2_resp, then one TURN bubble.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant_valid) w_state_nxt = (w_grant_src == SRC_D) ? SERVE_D : SERVE_I;
         SERVE_I: if (l2_resp) w_state_nxt = TURN;
         SERVE_D: if (l2_resp) w_state_nxt = TURN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture the winner's address, line and direction at grant; write beats read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else if (w_grant) begin
         if (w_grant_src == SRC_D) begin
            r_addr  <= dc_addr;
            r_wdata <= dc_wdata;
            r_write <= dc_write;
         end else begin
            r_addr  <= ic_addr;
            r_wdata <= '0;
            r_write <= 1'b0;
         end
      end
   end

   // Starvation counter (saturating) and last-granted source.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= '0;
         r_rr_last    <= SRC_I;
      end else if (w_grant) begin
         r_rr_last <= w_grant_src;
         if (w_grant_src == SRC_D && ic_read) begin
            if (!w_starve_hit) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end else begin
            r_starve_cnt <= '0;
         end
      end
   end

   // Outputs: L2 request from capture registers; response steered to the winner only.
   always_comb begin
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      ic_resp  = 1'b0;
      ic_rdata = '0;
      dc_resp  = 1'b0;
      dc_rdata = '0;
      case (r_state)
         SERVE_I: begin
            l2_read  = 1'b1;
            l2_addr  = r_addr;
            l2_wdata = r_wdata;
            if (l2_resp) begin
               ic_resp  = 1'b1;
               ic_rdata = l2_rdata;
            end
         end
         SERVE_D: begin
            l2_read  = !r_write;
            l2_write = r_write;
            l2_addr  = r_addr;
            l2_wdata = r_wdata;
            if (l2_resp) begin
               dc_resp  = 1'b1;
               dc_rdata = l2_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter in the default (fixed-priority) build.
module tb_l2_port_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         ic_read;
   logic [15:0]  ic_addr;
   logic [127:0] ic_rdata;
   logic         ic_resp;
   logic         dc_read;
   logic         dc_write;
   logic [15:0]  dc_addr;
   logic [127:0] dc_wdata;
   logic [127:0] dc_rdata;
   logic         dc_resp;
   logic         l2_read;
   logic         l2_write;
   logic [15:0]  l2_addr;
   logic [127:0] l2_wdata;
   logic [127:0] l2_rdata;
   logic         l2_resp;

   int n_cmp = 0;
   int n_err = 0;

   l2_port_arbiter #(.ADDR_W(16), .LINE_W(128), .STARVE_LIMIT(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .ic_read  (ic_read),
      .ic_addr  (ic_addr),
      .ic_rdata (ic_rdata),
      .ic_resp  (ic_resp),
      .dc_read  (dc_read),
      .dc_write (dc_write),
      .dc_addr  (dc_addr),
      .dc_wdata (dc_wdata),
      .dc_rdata (dc_rdata),
      .dc_resp  (dc_resp),
      .l2_read  (l2_read),
      .l2_write (l2_write),
      .l2_addr  (l2_addr),
      .l2_wdata (l2_wdata),
      .l2_rdata (l2_rdata),
      .l2_resp  (l2_resp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL rst_l2_read: got %0b expected 0", l2_read); end
      n_cmp++; if (l2_write !== 1'b0) begin n_err++; $display("FAIL rst_l2_write: got %0b expected 0", l2_write); end
      n_cmp++; if (l2_addr !== 16'h0) begin n_err++; $display("FAIL rst_l2_addr: got %0h expected 0", l2_addr); end
      n_cmp++; if ({ic_resp, dc_resp} !== 2'b00) begin n_err++; $display("FAIL rst_resp: got %0b expected 00", {ic_resp, dc_resp}); end
      step();
      reset = 1'b0;
   endtask

   task automatic test_lone_read();
      step();
      ic_read = 1'b1; ic_addr = 16'h1230;
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL t1_latency0: got %0b expected 0", l2_read); end
      step();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b1) begin n_err++; $display("FAIL t1_l2_read: got %0b expected 1", l2_read); end
      n_cmp++; if (l2_write !== 1'b0) begin n_err++; $display("FAIL t1_l2_write: got %0b expected 0", l2_write); end
      n_cmp++; if (l2_addr !== 16'h1230) begin n_err++; $display("FAIL t1_l2_addr: got %0h expected 1230", l2_addr); end
      repeat (4) step();
      n_cmp++; if (ic_resp !== 1'b0) begin n_err++; $display("FAIL t1_early_resp: got %0b expected 0", ic_resp); end
      step();
      l2_resp = 1'b1; l2_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      @(negedge clk);
      n_cmp++; if (ic_resp !== 1'b1) begin n_err++; $display("FAIL t1_ic_resp: got %0b expected 1", ic_resp); end
      n_cmp++; if (ic_rdata !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin n_err++; $display("FAIL t1_ic_rdata: got %0h expected 11112222333344445555666677778888", ic_rdata); end
      n_cmp++; if (dc_resp !== 1'b0) begin n_err++; $display("FAIL t1_dc_resp: got %0b expected 0", dc_resp); end
      n_cmp++; if (dc_rdata !== 128'h0) begin n_err++; $display("FAIL t1_dc_rdata: got %0h expected 0", dc_rdata); end
      step();
      l2_resp = 1'b0; l2_rdata = '0; ic_read = 1'b0;
      @(negedge clk);
      n_cmp++; if (ic_resp !== 1'b0) begin n_err++; $display("FAIL t1_resp_one_cycle: got %0b expected 0", ic_resp); end
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL t1_turn_read: got %0b expected 0", l2_read); end
      step();
   endtask

   task automatic test_fixed_priority();
      step();
      ic_read = 1'b1; ic_addr = 16'h0040;
      dc_write = 1'b1; dc_addr = 16'h8000; dc_wdata = {16{8'hA5}};
      step();
      @(negedge clk);
      n_cmp++; if (l2_write !== 1'b1) begin n_err++; $display("FAIL t2_d_write: got %0b expected 1", l2_write); end
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL t2_d_read: got %0b expected 0", l2_read); end
      n_cmp++; if (l2_addr !== 16'h8000) begin n_err++; $display("FAIL t2_d_addr: got %0h expected 8000", l2_addr); end
      n_cmp++; if (l2_wdata !== {16{8'hA5}}) begin n_err++; $display("FAIL t2_d_wdata: got %0h expected a5 x16", l2_wdata); end
      step();
      l2_resp = 1'b1; l2_rdata = '0;
      @(negedge clk);
      n_cmp++; if ({ic_resp, dc_resp} !== 2'b01) begin n_err++; $display("FAIL t2_d_resp: got %0b expected 01", {ic_resp, dc_resp}); end
      step();
      l2_resp = 1'b0; dc_write = 1'b0;
      @(negedge clk);
      n_cmp++; if ({l2_read, l2_write} !== 2'b00) begin n_err++; $display("FAIL t2_turn: got %0b expected 00", {l2_read, l2_write}); end
      step();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL t2_idle_gap: got %0b expected 0", l2_read); end
      step();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b1) begin n_err++; $display("FAIL t2_i_read: got %0b expected 1", l2_read); end
      n_cmp++; if (l2_addr !== 16'h0040) begin n_err++; $display("FAIL t2_i_addr: got %0h expected 0040", l2_addr); end
      step();
      l2_resp = 1'b1; l2_rdata = 128'hCAFE;
      @(negedge clk);
      n_cmp++; if (ic_rdata !== 128'hCAFE) begin n_err++; $display("FAIL t2_i_rdata: got %0h expected cafe", ic_rdata); end
      n_cmp++; if (dc_resp !== 1'b0) begin n_err++; $display("FAIL t2_i_dc_resp: got %0b expected 0", dc_resp); end
      step();
      l2_resp = 1'b0; l2_rdata = '0; ic_read = 1'b0;
      step();
   endtask

   task automatic test_starvation();
      bit          exp_d [6];
      logic [15:0] exp_addr;
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      step();
      ic_read = 1'b1; ic_addr = 16'h0100;
      dc_read = 1'b1; dc_addr = 16'h0200;
      for (int g = 0; g < 6; g++) begin
         exp_addr = exp_d[g] ? 16'h0200 : 16'h0100;
         step();
         @(negedge clk);
         n_cmp++; if (l2_addr !== exp_addr) begin n_err++; $display("FAIL t3_grant%0d_addr: got %0h expected %0h", g, l2_addr, exp_addr); end
         n_cmp++; if (l2_read !== 1'b1) begin n_err++; $display("FAIL t3_grant%0d_read: got %0b expected 1", g, l2_read); end
         step();
         l2_resp = 1'b1; l2_rdata = 128'(g + 1);
         @(negedge clk);
         n_cmp++; if (dc_resp !== exp_d[g]) begin n_err++; $display("FAIL t3_grant%0d_dc_resp: got %0b expected %0b", g, dc_resp, exp_d[g]); end
         n_cmp++; if (ic_resp !== !exp_d[g]) begin n_err++; $display("FAIL t3_grant%0d_ic_resp: got %0b expected %0b", g, ic_resp, !exp_d[g]); end
         step();
         l2_resp = 1'b0; l2_rdata = '0;
         if (g == 5) begin ic_read = 1'b0; dc_read = 1'b0; end
         step();
      end
   endtask

   task automatic test_addr_hold();
      step();
      ic_read = 1'b1; ic_addr = 16'h0010;
      step();
      @(negedge clk);
      n_cmp++; if (l2_addr !== 16'h0010) begin n_err++; $display("FAIL t4_addr_grant: got %0h expected 0010", l2_addr); end
      step();
      ic_addr = 16'h0020;
      @(negedge clk);
      n_cmp++; if (l2_addr !== 16'h0010) begin n_err++; $display("FAIL t4_addr_hold1: got %0h expected 0010", l2_addr); end
      step();
      @(negedge clk);
      n_cmp++; if (l2_addr !== 16'h0010) begin n_err++; $display("FAIL t4_addr_hold2: got %0h expected 0010", l2_addr); end
      step();
      l2_resp = 1'b1; l2_rdata = 128'h77;
      @(negedge clk);
      n_cmp++; if (l2_addr !== 16'h0010) begin n_err++; $display("FAIL t4_addr_at_resp: got %0h expected 0010", l2_addr); end
      n_cmp++; if (ic_resp !== 1'b1) begin n_err++; $display("FAIL t4_ic_resp: got %0b expected 1", ic_resp); end
      step();
      l2_resp = 1'b0; l2_rdata = '0; ic_read = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      step();
      dc_read = 1'b1; dc_addr = 16'h3000;
      step();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b1) begin n_err++; $display("FAIL t5_pre_read: got %0b expected 1", l2_read); end
      @(posedge clk);
      #2;
      l2_resp = 1'b1; l2_rdata = 128'hDEAD; reset = 1'b1;
      #1;
      n_cmp++; if ({l2_read, l2_write} !== 2'b00) begin n_err++; $display("FAIL t5_rst_l2: got %0b expected 00", {l2_read, l2_write}); end
      n_cmp++; if (dc_resp !== 1'b0) begin n_err++; $display("FAIL t5_rst_dc_resp: got %0b expected 0", dc_resp); end
      n_cmp++; if (dc_rdata !== 128'h0) begin n_err++; $display("FAIL t5_rst_dc_rdata: got %0h expected 0", dc_rdata); end
      l2_resp = 1'b0; l2_rdata = '0; dc_read = 1'b0;
      ic_read = 1'b1; ic_addr = 16'h0777;
      step();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b0) begin n_err++; $display("FAIL t5_post_idle: got %0b expected 0", l2_read); end
      step();
      @(negedge clk);
      n_cmp++; if (l2_read !== 1'b1) begin n_err++; $display("FAIL t5_post_grant: got %0b expected 1", l2_read); end
      n_cmp++; if (l2_addr !== 16'h0777) begin n_err++; $display("FAIL t5_post_addr: got %0h expected 0777", l2_addr); end
      step();
      l2_resp = 1'b1;
      step();
      l2_resp = 1'b0; ic_read = 1'b0;
      step();
   endtask

   task automatic test_spurious_and_illegal();
      step();
      l2_resp = 1'b1; l2_rdata = {8{16'hFFFF}};
      @(negedge clk);
      n_cmp++; if ({ic_resp, dc_resp} !== 2'b00) begin n_err++; $display("FAIL t6_idle_resp: got %0b expected 00", {ic_resp, dc_resp}); end
      n_cmp++; if ((ic_rdata | dc_rdata) !== 128'h0) begin n_err++; $display("FAIL t6_idle_rdata: got %0h expected 0", ic_rdata | dc_rdata); end
      step();
      l2_resp = 1'b0; l2_rdata = '0;
      @(negedge clk);
      n_cmp++; if ({l2_read, l2_write} !== 2'b00) begin n_err++; $display("FAIL t6_idle_stays: got %0b expected 00", {l2_read, l2_write}); end
      step();
      dc_read = 1'b1; dc_write = 1'b1; dc_addr = 16'h4440; dc_wdata = {8{16'h5A3C}};
      step();
      @(negedge clk);
      n_cmp++; if ({l2_read, l2_write} !== 2'b01) begin n_err++; $display("FAIL t6_both_dir: got %0b expected 01", {l2_read, l2_write}); end
      n_cmp++; if (l2_wdata !== {8{16'h5A3C}}) begin n_err++; $display("FAIL t6_wdata: got %0h expected 5a3c x8", l2_wdata); end
      step();
      dc_read = 1'b0; dc_write = 1'b0;
      @(negedge clk);
      n_cmp++; if (l2_write !== 1'b1) begin n_err++; $display("FAIL t6_dir_hold: got %0b expected 1", l2_write); end
      step();
      l2_resp = 1'b1; l2_rdata = 128'h0BAD_F00D;
      @(negedge clk);
      n_cmp++; if (dc_rdata !== 128'h0BAD_F00D) begin n_err++; $display("FAIL t6_dc_rdata: got %0h expected badf00d", dc_rdata); end
      step();
      @(negedge clk);
      n_cmp++; if ({ic_resp, dc_resp} !== 2'b00) begin n_err++; $display("FAIL t6_turn_resp: got %0b expected 00", {ic_resp, dc_resp}); end
      step();
      l2_resp = 1'b0; l2_rdata = '0;
      @(negedge clk);
      n_cmp++; if ({l2_read, l2_write} !== 2'b00) begin n_err++; $display("FAIL t6_final_idle: got %0b expected 00", {l2_read, l2_write}); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      ic_read = 1'b0; ic_addr = '0;
      dc_read = 1'b0; dc_write = 1'b0; dc_addr = '0; dc_wdata = '0;
      l2_rdata = '0; l2_resp = 1'b0;
      test_reset();
      test_lone_read();
      test_fixed_priority();
      test_starvation();
      test_addr_hold();
      test_reset_mid();
      test_spurious_and_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
